// File: rtl/cnn_pkg.sv
// Shared types and sizing constants for the CNN memory loader.
package cnn_pkg;

    // Bus widths toward the CNN memory and the per-region byte counter
    localparam int DATA_W = 8;
    localparam int ADDR_W = 19;
    localparam int CNT_W  = 18;

    // Default byte counts of the five regions, loaded in this order
    localparam int unsigned INPUT_BYTES_DEF = 10000;
    localparam int unsigned L1_BYTES_DEF    = 400;
    localparam int unsigned L2_BYTES_DEF    = 12800;
    localparam int unsigned L3_BYTES_DEF    = 230400;
    localparam int unsigned L4_BYTES_DEF    = 10600;

    // Region index; the value is driven directly onto the address bus
    typedef enum logic [2:0] {
        REG_INPUT = 3'd0,
        REG_L1    = 3'd1,
        REG_L2    = 3'd2,
        REG_L3    = 3'd3,
        REG_L4    = 3'd4
    } region_e;

    // Loader sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cnn_load_master.sv
// Streams the input image and the four layer weight sets from a byte source
// into the CNN memory, one write per accepted byte, region by region.
module cnn_load_master
    import cnn_pkg::*;
#(
    parameter int unsigned INPUT_BYTES = INPUT_BYTES_DEF,
    parameter int unsigned L1_BYTES    = L1_BYTES_DEF,
    parameter int unsigned L2_BYTES    = L2_BYTES_DEF,
    parameter int unsigned L3_BYTES    = L3_BYTES_DEF,
    parameter int unsigned L4_BYTES    = L4_BYTES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              chipselect,
    output logic              write,
    output logic              read,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              done,
    output logic [2:0]        region
);

    // Every region must hold at least one byte and fit the byte counter
    if (INPUT_BYTES == 0 || L1_BYTES == 0 || L2_BYTES == 0 ||
        L3_BYTES == 0 || L4_BYTES == 0) begin : g_zero_size
        $error("cnn_load_master: region sizes must be non-zero");
    end
    if (INPUT_BYTES > (1 << CNT_W) || L1_BYTES > (1 << CNT_W) ||
        L2_BYTES > (1 << CNT_W) || L3_BYTES > (1 << CNT_W) ||
        L4_BYTES > (1 << CNT_W)) begin : g_too_big
        $error("cnn_load_master: region size exceeds byte counter range");
    end

    state_e            state;
    region_e           region_q;
    logic [CNT_W-1:0]  byte_cnt;
    logic              accept;

    // Counter value of the final byte of a region
    function automatic logic [CNT_W-1:0] region_last(input region_e r);
        case (r)
            REG_INPUT: return CNT_W'(INPUT_BYTES - 1);
            REG_L1:    return CNT_W'(L1_BYTES - 1);
            REG_L2:    return CNT_W'(L2_BYTES - 1);
            REG_L3:    return CNT_W'(L3_BYTES - 1);
            REG_L4:    return CNT_W'(L4_BYTES - 1);
            default:   return '0;
        endcase
    endfunction

    // Abort and reset must block the handshake in the very cycle they appear
    assign s_ready = (state == ST_LOAD) && !abort && !reset;
    assign accept  = s_valid && s_ready;
    assign read    = 1'b0;
    assign region  = region_q;

    // Sequencer plus the write-strobe register one cycle behind acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            region_q   <= REG_INPUT;
            byte_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            address    <= '0;
        end else begin
            // write stage: replay the byte accepted on this edge
            chipselect <= accept;
            write      <= accept;
            writedata  <= accept ? s_data : '0;
            if (accept) begin
                address <= ADDR_W'(region_q);
            end
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state    <= ST_LOAD;
                        busy     <= 1'b1;
                        region_q <= REG_INPUT;
                        byte_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        region_q <= REG_INPUT;
                        byte_cnt <= '0;
                    end else if (accept) begin
                        if (byte_cnt == region_last(region_q)) begin
                            byte_cnt <= '0;
                            if (region_q == REG_L4) begin
                                state    <= ST_DONE;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                region_q <= REG_INPUT;
                            end else begin
                                region_q <= region_e'(region_q + 3'd1);
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_load_master.sv
// Directed bench for cnn_load_master with region sizes 3,2,4,1,2.
module tb_cnn_load_master;

    logic        clk = 1'b0;
    logic        reset, start, abort, s_valid;
    logic [7:0]  s_data;
    logic        s_ready, chipselect, write, read, busy, done;
    logic [18:0] address;
    logic [7:0]  writedata;
    logic [2:0]  region;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [18:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          wc_q[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          done_wr  = 0;

    int exp_addr[12] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 4, 4};

    cnn_load_master #(
        .INPUT_BYTES(3), .L1_BYTES(2), .L2_BYTES(4), .L3_BYTES(1), .L4_BYTES(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata),
        .busy(busy), .done(done), .region(region)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log write strobes and done pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (write) begin
            wa_q.push_back(address);
            wd_q.push_back(writedata);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (write && chipselect) done_wr++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1);
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        done_wr  = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present bytes 1..nbytes; returns just after the edge accepting the last one
    task automatic stream(input int nbytes, input bit toggle, input int start_idx);
        int         idx   = 0;
        int         guard = 0;
        bit         phase = 1'b1;
        bit         acc;
        logic [2:0] r_before;
        while (idx < nbytes && guard < 200) begin
            s_valid = toggle ? phase : 1'b1;
            s_data  = 8'(idx + 1);
            start   = (idx == start_idx) && s_valid;
            @(negedge clk);
            acc      = s_valid && s_ready;
            r_before = region;
            if (acc) begin
                total++;
                if (region !== 3'(exp_addr[idx])) begin
                    bad++;
                    $display("FAIL stream_region byte=%0d got=%0d want=%0d", idx, region, exp_addr[idx]);
                end
            end
            @(posedge clk); #1;
            if (!s_valid) begin
                total++;
                if (region !== r_before) begin
                    bad++;
                    $display("FAIL stall_region got=%0d want=%0d", region, r_before);
                end
            end
            if (acc) idx++;
            phase = ~phase;
            guard++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        total++;
        if (idx != nbytes) begin
            bad++;
            $display("FAIL stream_timeout got=%0d want=%0d", idx, nbytes);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if ({s_ready, chipselect, write, read, busy, done} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000", {s_ready, chipselect, write, read, busy, done});
        end
        total++;
        if ({address, writedata, region} !== 30'b0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", {address, writedata, region});
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_stream();
        clear_log();
        pulse_start();
        stream(12, 1'b0, -1);
        @(negedge clk);
        total++;
        if ({done, write, s_ready, busy} !== 4'b1100 || writedata !== 8'h0C) begin
            bad++;
            $display("FAIL stream_final got=%b/%h want=1100/0c", {done, write, s_ready, busy}, writedata);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (wa_q.size() != 12) begin
            bad++;
            $display("FAIL stream_count got=%0d want=12", wa_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                total++;
                if (wa_q[i] !== 19'(exp_addr[i]) || wd_q[i] !== 8'(i + 1)) begin
                    bad++;
                    $display("FAIL stream_write i=%0d got=%0d/%h want=%0d/%h", i, wa_q[i], wd_q[i], exp_addr[i], i + 1);
                end
            end
            for (int i = 0; i < 11; i++) begin
                total++;
                if (wc_q[i + 1] - wc_q[i] != 1) begin
                    bad++;
                    $display("FAIL stream_rate i=%0d got=%0d want=1", i, wc_q[i + 1] - wc_q[i]);
                end
            end
            total++;
            if (done_cnt != 1 || done_wr != 1 || done_cyc != wc_q[11]) begin
                bad++;
                $display("FAIL stream_done got=%0d/%0d/%0d want=1/1/%0d", done_cnt, done_wr, done_cyc, wc_q[11]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        pulse_start();
        stream(12, 1'b1, -1);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (wa_q.size() != 12) begin
            bad++;
            $display("FAIL bp_count got=%0d want=12", wa_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                total++;
                if (wa_q[i] !== 19'(exp_addr[i]) || wd_q[i] !== 8'(i + 1)) begin
                    bad++;
                    $display("FAIL bp_write i=%0d got=%0d/%h want=%0d/%h", i, wa_q[i], wd_q[i], exp_addr[i], i + 1);
                end
            end
            for (int i = 0; i < 11; i++) begin
                total++;
                if (wc_q[i + 1] - wc_q[i] != 2) begin
                    bad++;
                    $display("FAIL bp_spacing i=%0d got=%0d want=2", i, wc_q[i + 1] - wc_q[i]);
                end
            end
            total++;
            if (done_cnt != 1 || done_wr != 1 || done_cyc != wc_q[11]) begin
                bad++;
                $display("FAIL bp_done got=%0d/%0d/%0d want=1/1/%0d", done_cnt, done_wr, done_cyc, wc_q[11]);
            end
        end
    endtask

    task automatic test_abort();
        clear_log();
        pulse_start();
        stream(5, 1'b0, -1);
        abort = 1'b1; s_valid = 1'b1; s_data = 8'h06;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_ready got=%b want=0", s_ready);
        end
        @(posedge clk); #1;
        abort = 1'b0; s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (wa_q.size() != 5 || done_cnt != 0) begin
            bad++;
            $display("FAIL abort_writes got=%0d/%0d want=5/0", wa_q.size(), done_cnt);
        end
        total++;
        if (region !== 3'd0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle got=%0d/%b/%b want=0/0/0", region, busy, s_ready);
        end
        clear_log();
        pulse_start();
        stream(12, 1'b0, -1);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (wa_q.size() != 12 || done_cnt != 1) begin
            bad++;
            $display("FAIL reload_count got=%0d/%0d want=12/1", wa_q.size(), done_cnt);
        end else begin
            for (int i = 0; i < 12; i++) begin
                total++;
                if (wa_q[i] !== 19'(exp_addr[i]) || wd_q[i] !== 8'(i + 1)) begin
                    bad++;
                    $display("FAIL reload_write i=%0d got=%0d/%h want=%0d/%h", i, wa_q[i], wd_q[i], exp_addr[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        pulse_start();
        stream(4, 1'b0, -1);
        s_valid = 1'b1; s_data = 8'h05; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        total++;
        if (write !== 1'b0 || chipselect !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_strobe got=%b%b want=00", write, chipselect);
        end
        total++;
        if ({s_ready, read, busy, done, address, writedata, region} !== 34'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%h want=0", {s_ready, read, busy, done, address, writedata, region});
        end
        total++;
        if (wa_q.size() != 4 || done_cnt != 0) begin
            bad++;
            $display("FAIL rst_mid_writes got=%0d/%0d want=4/0", wa_q.size(), done_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_in_load();
        clear_log();
        pulse_start();
        stream(12, 1'b0, 6);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (wa_q.size() != 12 || done_cnt != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL startload_count got=%0d/%0d/%b want=12/1/0", wa_q.size(), done_cnt, busy);
        end else begin
            for (int i = 0; i < 12; i++) begin
                total++;
                if (wa_q[i] !== 19'(exp_addr[i]) || wd_q[i] !== 8'(i + 1)) begin
                    bad++;
                    $display("FAIL startload_write i=%0d got=%0d/%h want=%0d/%h", i, wa_q[i], wd_q[i], exp_addr[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_start_abort_idle();
        clear_log();
        start = 1'b1; abort = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL startabort_state got=%b%b want=00", busy, s_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || write !== 1'b0 || wa_q.size() != 0) begin
            bad++;
            $display("FAIL startabort_hold got=%b%b%b/%0d want=000/0", busy, s_ready, write, wa_q.size());
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_abort();
        test_reset_mid_load();
        test_start_in_load();
        test_start_abort_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
